apb_req_master: RTL and testbench

- Single-outstanding APB initiator. Converts a valid/ready request channel into APB SETUP/ACCESS transfers and returns the completion on a valid/ready response channel.
- Drives APB responders such as the register files in this codebase, from cores, DMA engines or debug units.
- Has a wait-state timeout so a hung responder cannot stall the requester forever.

---
 rtl/apb_req_master.sv | 162 ++++++++++++++++
 tb/tb_apb_req_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// ----------------------------------------------------------------------------
// apb_req_master
//   Single-outstanding APB initiator. It accepts one request on a valid/ready
//   channel, runs one APB SETUP/ACCESS transfer, and returns the completion on
//   a valid/ready response channel. A wait-state timeout aborts the transfer
//   if the responder never raises pready.
//
// Ports
//   pclk_i, preset_ni        clock (rising edge), synchronous active-low reset
//   req_*                    request channel (addr, write, wdata, strb, prot)
//   rsp_*                    response channel (rdata, err, timeout)
//   paddr_o .. pstrb_o       APB request signals, driven from latched request
//   pready_i, prdata_i,      APB completion inputs, only looked at in ACCESS
//   pslverr_i
// ----------------------------------------------------------------------------
module apb_req_master #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned StrbWidth     = DataWidth / 8,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                 pclk_i,
  input  logic                 preset_ni,
  // request channel
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [StrbWidth-1:0] req_strb_i,
  input  logic [2:0]           req_prot_i,   // apb_pkg::prot_t encoding
  // response channel
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  // APB
  output logic [AddrWidth-1:0] paddr_o,
  output logic [2:0]           pprot_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [DataWidth-1:0] pwdata_o,
  output logic [StrbWidth-1:0] pstrb_o,
  input  logic                 pready_i,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic                 pslverr_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int unsigned CntW     = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam bit          TmoEn    = (TimeoutCycles != 0);
  localparam int unsigned TmoLastI = TmoEn ? (TimeoutCycles - 1) : 0;
  localparam logic [CntW-1:0] TmoLast = CntW'(TmoLastI);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] strb_q, strb_d;
  logic [2:0]           prot_q, prot_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          // reads never carry strobes on the bus
          strb_d  = req_write_i ? req_strb_i : '0;
          prot_d  = req_prot_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready on the threshold cycle still counts as a normal completion
        if (pready_i) begin
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (TmoEn && (cnt_q == TmoLast)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign psel_o        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o     = (state_q == ST_ACCESS);
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign paddr_o       = addr_q;
  assign pprot_o       = prot_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_req_master #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(16)) dut (
    .pclk_i(clk), .preset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_tmo),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;     // ACCESS cycles before pready
    logic        never;     // responder never answers
    logic [31:0] prdata;
    logic        slverr;
    int          bp;        // cycles rsp_ready held low
    logic        late;      // pready pulsed after completion
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_acc;   // number of ACCESS cycles
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic run_vec(input vec_t v);
    int   acc;
    rsp_t e;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_prot  = v.prot;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.tmo = v.exp_tmo;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    // SETUP cycle
    chk("setup_psel",    {63'd0, psel},    64'd1);
    chk("setup_penable", {63'd0, penable}, 64'd0);
    chk("setup_ready",   {63'd0, req_ready}, 64'd0);
    chk("setup_paddr",   {32'd0, paddr},   {32'd0, v.addr});
    chk("setup_pwrite",  {63'd0, pwrite},  {63'd0, v.write});
    chk("setup_pwdata",  {32'd0, pwdata},  {32'd0, v.wdata});
    chk("setup_pstrb",   {60'd0, pstrb},   {60'd0, v.exp_pstrb});
    chk("setup_pprot",   {61'd0, pprot},   {61'd0, v.prot});
    @(negedge clk);
    acc = 0;
    while (psel && acc < 40) begin
      chk("access_penable", {63'd0, penable}, 64'd1);
      chk("access_paddr",   {32'd0, paddr},   {32'd0, v.addr});
      chk("access_pwdata",  {32'd0, pwdata},  {32'd0, v.wdata});
      acc++;
      if (!v.never && acc == v.waits + 1) begin
        pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      @(negedge clk);
    end
    pready = 1'b0;
    chk("access_cycles", 64'(acc), 64'(v.exp_acc));
    if (v.late) begin
      pready = 1'b1; prdata = 32'hBAD0BAD0; pslverr = 1'b1;
    end
    for (int i = 0; i < v.bp; i++) begin
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_psel",  {63'd0, psel},      64'd0);
      if (sb.size() != 0) begin
        chk("bp_rdata", {32'd0, rsp_rdata}, {32'd0, sb[0].rdata});
        chk("bp_err",   {63'd0, rsp_err},   {63'd0, sb[0].err});
        chk("bp_tmo",   {63'd0, rsp_tmo},   {63'd0, sb[0].tmo});
      end
      @(negedge clk);
    end
    pready = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
      chk("rsp_err",   {63'd0, rsp_err},   {63'd0, e.err});
      chk("rsp_tmo",   {63'd0, rsp_tmo},   {63'd0, e.tmo});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", {63'd0, rsp_valid}, 64'd0);
    chk("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    //          addr          wr    wdata         strb  prot  wt  nev   prdata        serr  bp lt    pstrb rdata         err   tmo   acc
    vecs[0] = '{32'h10, 1'b0, 32'h0,        4'h0, 3'd0, 0,  1'b0, 32'hCAFE0001, 1'b0, 0, 1'b0, 4'h0, 32'hCAFE0001, 1'b0, 1'b0, 1};
    vecs[1] = '{32'h4,  1'b1, 32'h12345678, 4'hF, 3'd2, 3,  1'b0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 4};
    vecs[2] = '{32'h8,  1'b0, 32'h11111111, 4'hF, 3'd1, 0,  1'b0, 32'h0000DEAD, 1'b1, 0, 1'b0, 4'h0, 32'h0000DEAD, 1'b1, 1'b0, 1};
    vecs[3] = '{32'hC,  1'b0, 32'h0,        4'h0, 3'd4, 0,  1'b1, 32'h0,        1'b0, 2, 1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 16};
    vecs[4] = '{32'h14, 1'b0, 32'h0,        4'h0, 3'd0, 0,  1'b0, 32'h5A5A1234, 1'b0, 5, 1'b0, 4'h0, 32'h5A5A1234, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h18, 1'b1, 32'h000000A5, 4'h3, 3'd7, 1,  1'b0, 32'h12121212, 1'b1, 0, 1'b0, 4'h3, 32'h0,        1'b1, 1'b0, 2};
    vecs[6] = '{32'h1C, 1'b0, 32'h0,        4'h0, 3'd3, 15, 1'b0, 32'h00000077, 1'b0, 0, 1'b0, 4'h0, 32'h00000077, 1'b0, 1'b0, 16};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_psel",      {63'd0, psel},      64'd0);
    chk("rst_penable",   {63'd0, penable},   64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_outs", {paddr, pwdata}, 64'd0);
    chk("rst_rsp",  {rsp_rdata, 24'd0, pstrb, pprot, pwrite, rsp_err, rsp_tmo, 1'b0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while a read sits in ACCESS: request is dropped, no response.
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b0; req_strb = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_access", {63'd0, penable}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_psel",    {63'd0, psel},      64'd0);
    chk("mid_rst_penable", {63'd0, penable},   64'd0);
    chk("mid_rst_ready",   {63'd0, req_ready}, 64'd1);
    chk("mid_rst_valid",   {63'd0, rsp_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      pready = 1'b1;
      @(negedge clk);
      chk("mid_no_rsp", {63'd0, rsp_valid | psel}, 64'd0);
    end
    pready = 1'b0;
    run_vec(vecs[0]);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
